// File: rtl/ucsbece154b_icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement and early restart.
// Latency: hits answered combinationally in the lookup cycle; a miss restarts on refill beat offset+1.
// Backpressure: Ready low stalls fetch while the FSM is in REQ/FILL; ReadEnable is ignored there.
module ucsbece154b_icache_assoc #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        Busy,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int WO = $clog2(BLOCK_WORDS);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 32 - WO - IW - 2;
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t state, state_next;

    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [WW-1:0]       ptr   [NUM_SETS];
    logic [TW-1:0]       tags  [NUM_WAYS][NUM_SETS];
    logic [31:0]         data  [NUM_WAYS][NUM_SETS][BLOCK_WORDS];

    // Refill context captured at the missing lookup
    logic [TW-1:0] l_tag;
    logic [IW-1:0] l_idx;
    logic [WO-1:0] l_off;
    logic [WW-1:0] l_way;
    logic          l_allv;
    logic          flush_pend;
    logic [WO-1:0] k;

    logic [WO-1:0] a_off;
    logic [IW-1:0] a_idx;
    logic [TW-1:0] a_tag;
    logic          unused_bits;

    assign a_off       = ReadAddress[WO+1:2];
    assign a_idx       = ReadAddress[WO+IW+1:WO+2];
    assign a_tag       = ReadAddress[31:WO+IW+2];
    assign unused_bits = ^ReadAddress[1:0];

    logic          hit;
    logic [31:0]   hit_word;
    logic [WW-1:0] victim;
    logic          all_valid;
    logic          lookup_hit, lookup_miss, beat, last_beat;
    logic [WW-1:0] ptr_next;

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit      = 1'b0;
        hit_word = 32'h0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[a_idx][w] && tags[w][a_idx] == a_tag) begin
                hit      = 1'b1;
                hit_word = data[w][a_idx][a_off];
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim    = ptr[a_idx];
        all_valid = &valid[a_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[a_idx][w]) victim = WW'(w);
        end
    end

    assign ptr_next = (ptr[l_idx] == WW'(NUM_WAYS - 1)) ? '0 : ptr[l_idx] + WW'(1);

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and fetch/memory-side outputs
    always_comb begin
        state_next     = state;
        Ready          = 1'b0;
        Instruction    = 32'h0;
        Busy           = 1'b0;
        MemReadRequest = 1'b0;
        MemReadAddress = 32'h0;
        lookup_hit     = 1'b0;
        lookup_miss    = 1'b0;
        beat           = 1'b0;
        last_beat      = 1'b0;
        case (state)
            IDLE: begin
                if (ReadEnable) begin
                    if (hit) begin
                        Ready       = 1'b1;
                        Instruction = hit_word;
                        lookup_hit  = 1'b1;
                    end else begin
                        lookup_miss = 1'b1;
                        state_next  = REQ;
                    end
                end
            end
            REQ: begin
                Busy           = 1'b1;
                MemReadRequest = 1'b1;
                MemReadAddress = {l_tag, l_idx, {(WO+2){1'b0}}};
                state_next     = FILL;
            end
            FILL: begin
                Busy = 1'b1;
                if (MemDataReady) begin
                    beat = 1'b1;
                    if (k == l_off) begin
                        Ready       = 1'b1;
                        Instruction = MemDataIn;
                    end
                    if (k == WO'(BLOCK_WORDS - 1)) begin
                        last_beat  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid bits, replacement pointers, refill context and counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                ptr[s]   <= '0;
            end
            l_tag      <= '0;
            l_idx      <= '0;
            l_off      <= '0;
            l_way      <= '0;
            l_allv     <= 1'b0;
            flush_pend <= 1'b0;
            k          <= '0;
            HitCount   <= 32'h0;
            MissCount  <= 32'h0;
        end else begin
            if (lookup_miss) begin
                l_tag      <= a_tag;
                l_idx      <= a_idx;
                l_off      <= a_off;
                l_way      <= victim;
                l_allv     <= all_valid;
                flush_pend <= 1'b0;
                k          <= '0;
            end
            if (state != IDLE && Flush) flush_pend <= 1'b1;
            if (beat) k <= k + WO'(1);
            // Flush in IDLE takes effect after this cycle's lookup was answered
            if (state == IDLE && Flush) begin
                for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
            end
            if (last_beat) begin
                if (flush_pend || Flush) begin
                    for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
                end else begin
                    valid[l_idx][l_way] <= 1'b1;
                end
                if (l_allv) ptr[l_idx] <= ptr_next;
            end
            if (lookup_hit && HitCount != 32'hFFFF_FFFF)  HitCount  <= HitCount + 32'd1;
            if (lookup_miss && MissCount != 32'hFFFF_FFFF) MissCount <= MissCount + 32'd1;
        end
    end

    // Line storage; contents only matter once the valid bit is set
    always_ff @(posedge Clk) begin
        if (beat)      data[l_way][l_idx][k] <= MemDataIn;
        if (last_beat) tags[l_way][l_idx]    <= l_tag;
    end

endmodule

// File: tb/tb_ucsbece154b_icache_assoc.sv
// Bench for the set-associative instruction cache.
// Directed steps followed by randomized reads against a block-level reference model.
// Memory side answered by the bench with optional idle gaps between beats.
module tb_ucsbece154b_icache_assoc;

    localparam int NS = 8;
    localparam int NW = 4;
    localparam int BW = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadAddress = 32'h0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] MemDataIn = 32'h0;
    logic        MemDataReady = 1'b0;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    ucsbece154b_icache_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW)) dut (
        .Clk(Clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Flush(Flush), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per set/way, which memory block (address >> 4) is resident
    bit          m_valid [NS][NW];
    logic [31:0] m_blk   [NS][NW];
    int          m_ptr   [NS];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h0) return 32'hA0 + {30'h0, w[3:2]};
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic void model_clear_lines();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear_lines();
        for (int s = 0; s < NS; s++) m_ptr[s] = 0;
        exp_hits = 0;
        exp_miss = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] blk);
        int s;
        s = int'(blk % NS);
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_blk[s][w] == blk) return 1'b1;
        return 1'b0;
    endfunction

    // One fetch; on a miss the bench plays the memory and checks the refill sequence
    task automatic do_read(input logic [31:0] addr, input bit flush_idle, input int flush_beat,
                           output bit obs_hit);
        logic [31:0] blk;
        int          s, off, victim, gap;
        bit          allv;
        blk = addr >> 4;
        s   = int'(blk % NS);
        off = int'((addr >> 2) % BW);
        @(negedge Clk);
        ReadEnable = 1'b1; ReadAddress = addr; Flush = flush_idle; MemDataReady = 1'b0;
        #1;
        obs_hit = Ready;
        if (model_hit(blk)) begin
            chk("hit_ready", {31'h0, Ready}, 32'd1);
            chk("hit_data", Instruction, memw(addr));
            exp_hits++;
            if (flush_idle) model_clear_lines();
        end else begin
            chk("miss_ready", {31'h0, Ready}, 32'd0);
            victim = -1;
            for (int w = 0; w < NW; w++)
                if (!m_valid[s][w] && victim < 0) victim = w;
            allv = (victim < 0);
            if (allv) victim = m_ptr[s];
            exp_miss++;
            if (flush_idle) model_clear_lines();
            @(negedge Clk);
            ReadEnable = 1'($urandom); ReadAddress = $urandom; Flush = 1'b0;
            #1;
            chk("req_pulse", {31'h0, MemReadRequest}, 32'd1);
            chk("req_addr", MemReadAddress, blk << 4);
            chk("req_busy", {31'h0, Busy}, 32'd1);
            for (int i = 0; i < BW; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(negedge Clk);
                    MemDataReady = 1'b0; MemDataIn = $urandom; Flush = 1'b0;
                    #1;
                    chk("gap_ready", {31'h0, Ready}, 32'd0);
                    chk("gap_req", {31'h0, MemReadRequest}, 32'd0);
                end
                @(negedge Clk);
                MemDataReady = 1'b1; MemDataIn = memw((blk << 4) + 32'(i * 4));
                Flush = (i == flush_beat);
                #1;
                chk("fill_busy", {31'h0, Busy}, 32'd1);
                chk("fill_ready", {31'h0, Ready}, {31'h0, (i == off)});
                if (i == off) chk("restart_data", Instruction, memw(addr));
            end
            @(negedge Clk);
            MemDataReady = 1'b0; Flush = 1'b0; ReadEnable = 1'b0;
            #1;
            chk("fill_done_busy", {31'h0, Busy}, 32'd0);
            m_valid[s][victim] = 1'b1;
            m_blk[s][victim]   = blk;
            if (allv) m_ptr[s] = (m_ptr[s] + 1) % NW;
            if (flush_beat >= 0) model_clear_lines();
        end
    endtask

    task automatic chk_counts();
        @(negedge Clk);
        ReadEnable = 1'b0; Flush = 1'b0; MemDataReady = 1'b0;
        #1;
        chk("hit_count", HitCount, 32'(exp_hits));
        chk("miss_count", MissCount, 32'(exp_miss));
    endtask

    // Miss, take one beat, then reset mid-refill and feed the remaining beats
    task automatic read_reset(input logic [31:0] addr);
        logic [31:0] blk;
        blk = addr >> 4;
        @(negedge Clk);
        ReadEnable = 1'b1; ReadAddress = addr; Flush = 1'b0; MemDataReady = 1'b0;
        #1;
        chk("rst_miss_ready", {31'h0, Ready}, 32'd0);
        @(negedge Clk);
        ReadEnable = 1'b0;
        #1;
        chk("rst_req_pulse", {31'h0, MemReadRequest}, 32'd1);
        @(negedge Clk);
        MemDataReady = 1'b1; MemDataIn = memw(blk << 4);
        #1;
        chk("rst_beat0_busy", {31'h0, Busy}, 32'd1);
        @(negedge Clk);
        MemDataReady = 1'b0; Reset = 1'b1;
        #1;
        chk("rst_busy", {31'h0, Busy}, 32'd0);
        chk("rst_ready", {31'h0, Ready}, 32'd0);
        chk("rst_req", {31'h0, MemReadRequest}, 32'd0);
        chk("rst_instr", Instruction, 32'h0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 1; i < BW; i++) begin
            @(negedge Clk);
            MemDataReady = 1'b1; MemDataIn = memw((blk << 4) + 32'(i * 4));
            #1;
            chk("late_beat_ready", {31'h0, Ready}, 32'd0);
            chk("late_beat_busy", {31'h0, Busy}, 32'd0);
        end
        @(negedge Clk);
        MemDataReady = 1'b0;
    endtask

    initial begin
        bit          h;
        logic [31:0] a;
        bit          fi;
        int          fb;

        model_reset();
        repeat (2) @(negedge Clk);
        #1;
        chk("reset_instr", Instruction, 32'h0);
        chk("reset_ready", {31'h0, Ready}, 32'd0);
        chk("reset_busy", {31'h0, Busy}, 32'd0);
        chk("reset_req", {31'h0, MemReadRequest}, 32'd0);
        chk("reset_addr", MemReadAddress, 32'h0);
        chk("reset_hits", HitCount, 32'h0);
        chk("reset_miss", MissCount, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // Cold miss with early restart on word 0, then a same-line hit
        do_read(32'h0000_0000, 1'b0, -1, h); chk("t1_first_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0004, 1'b0, -1, h); chk("t1_then_hit", {31'h0, h}, 32'd1);
        chk_counts();
        chk("t1_hits_is_1", HitCount, 32'd1);
        chk("t1_miss_is_1", MissCount, 32'd1);

        // Restart on the last word of a block
        do_read(32'h0000_001C, 1'b0, -1, h); chk("t2_miss", {31'h0, h}, 32'd0);

        // Fill set 0, evict way 0, check the survivors
        do_read(32'h0000_0000, 1'b0, -1, h); chk("t3_000_hit", {31'h0, h}, 32'd1);
        do_read(32'h0000_0080, 1'b0, -1, h); chk("t3_080_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0100, 1'b0, -1, h); chk("t3_100_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0180, 1'b0, -1, h); chk("t3_180_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0200, 1'b0, -1, h); chk("t3_200_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0080, 1'b0, -1, h); chk("t3_080_hit", {31'h0, h}, 32'd1);
        do_read(32'h0000_0000, 1'b0, -1, h); chk("t3_000_evicted", {31'h0, h}, 32'd0);

        // Flush during beat 2 of a refill invalidates the new line too
        do_read(32'h0000_0308, 1'b0, 1, h);  chk("t4_miss", {31'h0, h}, 32'd0);
        do_read(32'h0000_0308, 1'b0, -1, h); chk("t4_remiss", {31'h0, h}, 32'd0);

        // Flush alongside a hit: hit reported, then the line is gone
        do_read(32'h0000_030C, 1'b1, -1, h); chk("t5_flush_hit", {31'h0, h}, 32'd1);
        do_read(32'h0000_030C, 1'b0, -1, h); chk("t5_after_flush", {31'h0, h}, 32'd0);

        // Reset mid-refill, then a fresh miss and five hits
        read_reset(32'h0000_0048);
        do_read(32'h0000_0048, 1'b0, -1, h); chk("t6_fresh_miss", {31'h0, h}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_read(32'h0000_0048, 1'b0, -1, h);
        end
        chk_counts();
        chk("t6_hits_is_5", HitCount, 32'd5);
        chk("t6_miss_is_1", MissCount, 32'd1);

        // Randomized traffic over 8 tags per set so lines are reused and evicted
        for (int n = 0; n < 200; n++) begin
            a  = (32'($urandom_range(0, 7)) << 7) | (32'($urandom_range(0, 31)) << 2)
                 | 32'($urandom_range(0, 3));
            fi = ($urandom_range(0, 30) == 0);
            fb = ($urandom_range(0, 20) == 0) ? int'($urandom_range(0, BW - 1)) : -1;
            do_read(a, fi, fb, h);
            if (n % 50 == 49) chk_counts();
        end
        chk_counts();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_icache_assoc.md
# ucsbece154b_icache_assoc

Parametrised N-way set-associative instruction cache; next generation of the direct-mapped fetch cache. Sits between the pipeline fetch stage (PC in, instruction plus Ready out, Ready drives fetch stall) and the SDRAM instruction memory (block-refill handshake). Adds configurable sets, ways and block size, invalid-first/round-robin replacement, early restart on the requested word, a whole-cache Flush, and saturating hit/miss counters.

## Interface
- NUM_SETS, 8, sets; power of two, ≥2
- NUM_WAYS, 4, ways per set; power of two, ≥1
- BLOCK_WORDS, 4, 32-bit words per block; power of two, ≥2
- Clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears every valid bit, replacement pointer, counter and FSM state
- ReadEnable  in  1  fetch request this cycle
- ReadAddress  in  32  byte address of instruction; bits [1:0] ignored
- Flush  in  1  invalidate all lines
- Instruction  out  32  fetched word, valid only while Ready=1
- Ready  out  1  Instruction valid this cycle
- Busy  out  1  FSM not in IDLE
- MemReadAddress  out  32  block-aligned refill address
- MemReadRequest  out  1  one-cycle refill request pulse
- MemDataIn  in  32  refill data beat
- MemDataReady  in  1  MemDataIn valid; one pulse per beat
- HitCount  out  32  saturating lookup-hit count
- MissCount  out  32  saturating miss count

## Operation
- Address split: word offset = ReadAddress[2+WO-1:2], WO=log2(BLOCK_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage per way/set: valid bit, tag, BLOCK_WORDS data words. One round-robin victim pointer per set, log2(NUM_WAYS) bits.
- States: IDLE, REQ, FILL.
- IDLE, ReadEnable=1, hit in any valid way: Ready=1 and Instruction=hit word combinationally in the same cycle; HitCount+1. Stay IDLE.
- IDLE, ReadEnable=1, miss: Ready=0; latch tag, index, word offset; choose victim as lowest-numbered invalid way, else the pointer way; MissCount+1; go REQ.
- REQ: MemReadRequest=1 and MemReadAddress={tag,index,WO+2 zero bits} for exactly one cycle; go FILL with beat counter k=0.
- FILL: each MemDataReady writes MemDataIn into word k of the victim and increments k. Beats arrive in order, word 0 first. On the beat where k equals the latched offset: Ready=1, Instruction=MemDataIn (early restart, one cycle). On beat BLOCK_WORDS-1: write tag, set valid; if all ways were valid at victim selection, pointer=pointer+1 mod NUM_WAYS; go IDLE.
- ReadEnable is ignored outside IDLE; Ready=0 in REQ and in FILL except on the restart beat.
- Flush in IDLE: all valid bits cleared at the next edge; any lookup that cycle is still answered from pre-flush contents. Flush in REQ/FILL: latched and applied when FILL ends, and also invalidates the line just filled.
- Counters saturate at 0xFFFFFFFF.
- MemDataReady in IDLE or REQ is ignored.

## Timing
- Reset values: Instruction=0, Ready=0, Busy=0, MemReadRequest=0, MemReadAddress=0, HitCount=0, MissCount=0, all lines invalid, all pointers 0, state IDLE.
- Hit latency 0 cycles; no throughput limit, one hit per cycle.
- Miss: request cycle t (IDLE). REQ is t+1 and carries the MemReadRequest pulse. Ready coincides with beat offset+1 of the refill. Next lookup is possible the cycle after the last beat.
- Busy=1 for every cycle in REQ and FILL.
- Reset mid-refill forces all outputs to reset values immediately. Later beats from the same refill are ignored. No partial line ever becomes valid.
- Simultaneous Flush and hit in IDLE: hit reported, then all lines invalid.

## Test plan
- Reset, then read 0x00000000. Required: Ready=0; one MemReadRequest pulse with MemReadAddress=0x00000000. Beats 0xA0,0xA1,0xA2,0xA3 → Ready with Instruction=0xA0 on the first beat. Then read 0x00000004 → same-cycle Ready, Instruction=0xA1. HitCount=1, MissCount=1.
- Read 0x0000001C (set 1, word 3). Required: MemReadAddress=0x00000010; Ready only on the fourth beat, with Instruction equal to the fourth beat.
- Fill set 0 from 0x000, 0x080, 0x100, 0x180 into ways 0–3, then read 0x200. Required: miss, evicts way 0, pointer becomes 1. Re-read 0x000 → miss; 0x080 → hit.
- Assert Flush during beat 2 of a refill. Required: refill completes and Busy drops after beat 4. Re-reading the same address misses.
- Assert Reset after beat 1 of a refill. Required: Busy=0, Ready=0, MemReadRequest=0 at once. Remaining beats are ignored. Same address then misses with a fresh request.
- Read the same hit address 5 times after a single miss. Required: HitCount=5, MissCount=1.
